// File: rtl/if_fetch_bridge.sv
// -----------------------------------------------------------------------------
// if_fetch_bridge
//
// Instruction-fetch responder for the RV32I IF stage. It takes the fetch
// address from pc_reg and runs a request/acknowledge read on the instruction
// bus. Each fetched instruction is presented with its PC to the IF/ID
// register. The PC is held through stall_req_out, so it advances exactly
// once per delivered instruction. A jump flush drops any fetch that is
// still in flight.
//
// Ports
//   clk_in, reset_in     clock, synchronous active-high reset
//   pc_in                fetch address from pc_reg
//   chip_enable_in       fetching allowed only while high
//   jump_flush_in        branch/jump redirect this cycle
//   stall_in             pipeline stall vector; bit 1 freezes IF/ID
//   bus_req_out          bus read request
//   bus_addr_out         bus read address, stable while bus_req_out is high
//   bus_ack_in           single-cycle acknowledge, data valid in same cycle
//   bus_rdata_in         bus read data
//   inst_out             fetched instruction (NOP_INST when not valid)
//   inst_pc_out          address of inst_out
//   inst_valid_out       inst_out / inst_pc_out are valid
//   misalign_out         delivered entry came from a misaligned address
//   stall_req_out        asks ctrl to hold the PC
// -----------------------------------------------------------------------------
module if_fetch_bridge #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INST   = 32'h00000013
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic                  chip_enable_in,
  input  logic                  jump_flush_in,
  input  logic [5:0]            stall_in,
  output logic                  bus_req_out,
  output logic [ADDR_WIDTH-1:0] bus_addr_out,
  input  logic                  bus_ack_in,
  input  logic [DATA_WIDTH-1:0] bus_rdata_in,
  output logic [DATA_WIDTH-1:0] inst_out,
  output logic [ADDR_WIDTH-1:0] inst_pc_out,
  output logic                  inst_valid_out,
  output logic                  misalign_out,
  output logic                  stall_req_out
);

  // Level of stall_in[1] that freezes IF/ID.
  localparam logic STOP = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, REQ, RESP} state_t;

  state_t                  state, state_d;
  logic                    discard, discard_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   inst_q, inst_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic                    valid_q, valid_d;
  logic                    mis_q, mis_d;
  logic                    misaligned;

  assign misaligned = (addr_q[1:0] != 2'b00);

  // NOTE: every variable gets its default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d   = state;
    discard_d = discard;
    addr_d    = addr_q;
    inst_d    = inst_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    mis_d     = mis_q;

    if (!chip_enable_in) begin
      state_d   = IDLE;
      discard_d = 1'b0;
      valid_d   = 1'b0;
      mis_d     = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          addr_d  = pc_in;
          state_d = REQ;
        end
        ISSUE: begin
          // Wait out the flush so the jump target is what gets latched.
          if (!jump_flush_in) begin
            addr_d  = pc_in;
            state_d = REQ;
          end
        end
        REQ: begin
          if (misaligned) begin
            // No bus access. Deliver a NOP tagged as misaligned, unless
            // this fetch is being thrown away.
            if (discard || jump_flush_in) begin
              discard_d = 1'b0;
              state_d   = ISSUE;
            end else begin
              inst_d  = NOP_INST;
              pc_d    = addr_q;
              valid_d = 1'b1;
              mis_d   = 1'b1;
              state_d = RESP;
            end
          end else if (bus_ack_in) begin
            // A flush in the ack cycle wins over the returning data.
            if (discard || jump_flush_in) begin
              discard_d = 1'b0;
              state_d   = ISSUE;
            end else begin
              inst_d  = bus_rdata_in;
              pc_d    = addr_q;
              valid_d = 1'b1;
              mis_d   = 1'b0;
              state_d = RESP;
            end
          end else if (jump_flush_in) begin
            // The request cannot be withdrawn. Remember to drop its data.
            discard_d = 1'b1;
          end
        end
        RESP: begin
          if (jump_flush_in) begin
            valid_d = 1'b0;
            state_d = ISSUE;
          end else if (stall_in[1] != STOP) begin
            valid_d = 1'b0;
            mis_d   = 1'b0;
            addr_d  = pc_in;
            state_d = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples values from before the edge.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state   <= IDLE;
      discard <= 1'b0;
      addr_q  <= '0;
      inst_q  <= NOP_INST;
      pc_q    <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state   <= state_d;
      discard <= discard_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

  assign bus_req_out    = (state == REQ) && !misaligned;
  assign bus_addr_out   = bus_req_out ? addr_q : '0;
  assign inst_out       = valid_q ? inst_q : NOP_INST;
  assign inst_pc_out    = pc_q;
  assign inst_valid_out = valid_q;
  assign misalign_out   = mis_q;

  // The PC may advance only in the completion cycle of a fetch that is kept.
  assign stall_req_out = chip_enable_in &&
                         !((state == REQ) && !discard &&
                           (bus_ack_in || misaligned) && !jump_flush_in);

endmodule
